// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: issues req/ack reads of instruction memory for the
// current PC, buffers {pc, instr} pairs in a small FIFO for decode, and pulses
// pc_advance to step the program counter. A flush discards the in-flight read
// (via DROP) and empties the buffer.
//
// Handshakes:
//   imem: imem_req is held with a stable imem_addr until a cycle with imem_ack=1;
//         that cycle completes the read. imem_ack is ignored while imem_req=0.
//   id:   an entry transfers on any cycle where id_valid=1 and id_ready=1;
//         id_* hold steady while id_valid=1 and id_ready=0.
module instr_fetch_stage #(
  parameter int FIFO_DEPTH  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [TW-1:0]   tmo_q, tmo_d, tmo_inc;
  logic            err_q, err_d;

  logic [31:0]     pc_mem  [FIFO_DEPTH];
  logic [31:0]     ins_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic [CW:0]     occ;
  logic            room, can_try, issue, misalign, push, pop;

  // Occupancy counts the read currently completing in BUSY, ignoring any pop.
  assign occ      = {1'b0, count_q} + {{CW{1'b0}}, (state_q == S_BUSY)};
  assign room     = occ < (CW+1)'(FIFO_DEPTH);
  assign can_try  = ~reset & ~flush & ~err_q & room;
  assign issue    = can_try & (pc_in[1:0] == 2'b00);
  assign misalign = can_try & (pc_in[1:0] != 2'b00);
  assign tmo_inc  = tmo_q + 1'b1;

  assign id_valid  = (count_q != '0);
  assign pop       = id_valid & id_ready;
  assign imem_req  = (state_q == S_BUSY) || (state_q == S_DROP);
  assign imem_addr = addr_q;
  assign fetch_err = err_q;
  assign dbg_state = state_q;
  assign id_pc     = id_valid ? pc_mem[rd_ptr_q]  : 32'd0;
  assign id_instr  = id_valid ? ins_mem[rd_ptr_q] : 32'd0;
  assign id_pc4    = id_pc + 32'd4;

  // Fetch FSM next-state, request bookkeeping and push/advance decisions.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    push       = 1'b0;
    pc_advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          pc_advance = 1'b1;
          addr_d     = pc_in;
          tmo_d      = '0;
          state_d    = S_BUSY;
        end else if (misalign) begin
          err_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (imem_ack) begin
          push = ~flush;
          if (issue) begin
            pc_advance = 1'b1;
            addr_d     = pc_in;
            tmo_d      = '0;
          end else begin
            if (misalign) err_d = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tmo_inc == TW'(ACK_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
          if (flush) state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          state_d = S_IDLE;
        end else if (tmo_inc == TW'(ACK_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, address, timeout and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Buffer storage; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      pc_mem[wr_ptr_q]  <= addr_q;
      ins_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  // Buffer pointers and occupancy; flush empties the buffer outright.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: memory responder with programmable
// ack latency, PC register emulation, and per-scenario checks.
module tb_instr_fetch_stage;

  localparam logic [31:0] KEY = 32'h13579BDF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  int  mem_lat;
  bit  mem_never;
  bit  bad_data;
  bit  pc_follow;
  bit  saw_bad;
  int  req_cycles;
  int  adv_cnt;
  int  req_seen;
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];
  logic [31:0] got_pc4[$];
  logic [31:0] ack_q[$];

  instr_fetch_stage #(.FIFO_DEPTH(2), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_advance(pc_advance),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4),
    .fetch_err(fetch_err), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Hold reset for two edges, clear bench bookkeeping, release after an edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_pc.delete(); got_ins.delete(); got_pc4.delete(); ack_q.delete();
    mem_lat = 0; mem_never = 0; bad_data = 0; pc_follow = 1; saw_bad = 0;
    req_cycles = 0; adv_cnt = 0; req_seen = 0;
  endtask

  // One clock: drive inputs at negedge, observe, then emulate memory/PC after posedge.
  task automatic cycle(input logic fl, input logic rdy);
    logic adv, req_now, ack_now;
    @(negedge clk);
    flush = fl;
    id_ready = rdy;
    ack_now = imem_req && !mem_never && (req_cycles >= mem_lat);
    imem_ack = ack_now;
    imem_rdata = ack_now ? (bad_data ? 32'hDEADBEEF : (imem_addr ^ KEY)) : 32'h0;
    #1;
    adv = pc_advance;
    req_now = imem_req;
    if (adv) adv_cnt++;
    if (req_now) req_seen++;
    if (ack_now) ack_q.push_back(imem_addr);
    if (id_valid && id_instr == 32'hDEADBEEF) saw_bad = 1'b1;
    if (id_valid && rdy && !fl) begin
      got_pc.push_back(id_pc);
      got_ins.push_back(id_instr);
      got_pc4.push_back(id_pc4);
    end
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (ack_now) req_cycles = 0;
    else if (req_now) req_cycles++;
    if (adv && pc_follow) pc_in = pc_in + 32'd4;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; pc_in = 32'h0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    tests_run++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_id: got v=%b i=%h p=%h want 0", id_valid, id_instr, id_pc); end
    tests_run++; if (id_pc4 !== 32'h4) begin tests_failed++; $display("FAIL reset_pc4: got %h want 4", id_pc4); end
    tests_run++; if (fetch_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", fetch_err); end
    tests_run++; if (pc_advance !== 1'b0) begin tests_failed++; $display("FAIL reset_adv: got %b want 0", pc_advance); end
    tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    pc_in = 32'h0;
    cycle(1'b0, 1'b1);
    tests_run++; if (adv_cnt !== 1 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL stream_first_req: got adv=%0d req=%b addr=%h want 1 1 0", adv_cnt, imem_req, imem_addr); end
    cycle(1'b0, 1'b1);
    tests_run++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin tests_failed++; $display("FAIL stream_first_valid: got v=%b pc=%h want 1 0", id_valid, id_pc); end
    for (int i = 0; i < 30 && got_pc.size() < 3; i++) cycle(1'b0, 1'b1);
    tests_run++; if (got_pc.size() < 3) begin tests_failed++; $display("FAIL stream_count: got %0d want 3", got_pc.size()); end
    for (int i = 0; i < 3; i++) begin
      e = 32'(i * 4);
      tests_run++; if (got_pc[i] !== e || got_ins[i] !== (e ^ KEY) || got_pc4[i] !== e + 32'd4) begin tests_failed++; $display("FAIL stream_entry%0d: got pc=%h ins=%h pc4=%h want %h %h %h", i, got_pc[i], got_ins[i], got_pc4[i], e, e ^ KEY, e + 32'd4); end
      tests_run++; if (ack_q[i] !== e) begin tests_failed++; $display("FAIL stream_addr%0d: got %h want %h", i, ack_q[i], e); end
    end
    tests_run++; if (adv_cnt !== ack_q.size() + (imem_req ? 1 : 0)) begin tests_failed++; $display("FAIL stream_adv: got %0d want %0d", adv_cnt, ack_q.size() + (imem_req ? 1 : 0)); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    do_reset();
    pc_in = 32'h100;
    repeat (10) cycle(1'b0, 1'b0);
    tests_run++; if (adv_cnt !== 2) begin tests_failed++; $display("FAIL bp_adv: got %0d want 2", adv_cnt); end
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_req: got %b want 0", imem_req); end
    tests_run++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin tests_failed++; $display("FAIL bp_head: got v=%b pc=%h want 1 100", id_valid, id_pc); end
    for (int i = 0; i < 30 && got_pc.size() < 4; i++) cycle(1'b0, 1'b1);
    tests_run++; if (got_pc.size() < 4) begin tests_failed++; $display("FAIL bp_count: got %0d want 4", got_pc.size()); end
    for (int i = 0; i < 4; i++) begin
      e = 32'h100 + 32'(i * 4);
      tests_run++; if (got_pc[i] !== e || got_ins[i] !== (e ^ KEY)) begin tests_failed++; $display("FAIL bp_entry%0d: got pc=%h ins=%h want %h %h", i, got_pc[i], got_ins[i], e, e ^ KEY); end
    end
  endtask

  task automatic test_flush_busy();
    do_reset();
    pc_in = 32'h200; mem_lat = 3; bad_data = 1; pc_follow = 0;
    cycle(1'b0, 1'b1);
    pc_in = 32'h300;
    cycle(1'b1, 1'b1);
    pc_follow = 1;
    tests_run++; if (dbg_state !== 2'd2 || imem_req !== 1'b1 || imem_addr !== 32'h200 || id_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_drop: got st=%0d req=%b addr=%h v=%b want 2 1 200 0", dbg_state, imem_req, imem_addr, id_valid); end
    repeat (3) cycle(1'b0, 1'b1);
    tests_run++; if (adv_cnt !== 1 || dbg_state !== 2'd0 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL flush_wait: got adv=%0d st=%0d req=%b want 1 0 0", adv_cnt, dbg_state, imem_req); end
    tests_run++; if (ack_q.size() !== 1 || ack_q[0] !== 32'h200) begin tests_failed++; $display("FAIL flush_ackaddr: got n=%0d a=%h want 1 200", ack_q.size(), ack_q[0]); end
    cycle(1'b0, 1'b1);
    tests_run++; if (adv_cnt !== 2) begin tests_failed++; $display("FAIL flush_reissue: got %0d want 2", adv_cnt); end
    bad_data = 0; mem_lat = 0;
    for (int i = 0; i < 20 && got_pc.size() < 1; i++) cycle(1'b0, 1'b1);
    tests_run++; if (got_pc[0] !== 32'h300 || got_ins[0] !== (32'h300 ^ KEY)) begin tests_failed++; $display("FAIL flush_next: got pc=%h ins=%h want 300 %h", got_pc[0], got_ins[0], 32'h300 ^ KEY); end
    tests_run++; if (saw_bad !== 1'b0) begin tests_failed++; $display("FAIL flush_void: got %b want 0", saw_bad); end
  endtask

  task automatic test_flush_ack();
    do_reset();
    pc_in = 32'h400;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    tests_run++; if (id_valid !== 1'b1 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL fack_setup: got v=%b req=%b want 1 1", id_valid, imem_req); end
    pc_follow = 0;
    pc_in = 32'h802;
    cycle(1'b1, 1'b1);
    tests_run++; if (dbg_state !== 2'd0 || id_valid !== 1'b0 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL fack_empty: got st=%0d v=%b req=%b want 0 0 0", dbg_state, id_valid, imem_req); end
    tests_run++; if (got_pc.size() !== 0) begin tests_failed++; $display("FAIL fack_pops: got %0d want 0", got_pc.size()); end
  endtask

  task automatic test_timeout();
    int err_at;
    do_reset();
    pc_in = 32'h500; mem_never = 1; pc_follow = 0;
    err_at = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1);
      if (fetch_err === 1'b1 && err_at < 0) err_at = req_seen;
    end
    tests_run++; if (err_at !== 15) begin tests_failed++; $display("FAIL tmo_cycles: got %0d want 15", err_at); end
    tests_run++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || adv_cnt !== 1) begin tests_failed++; $display("FAIL tmo_state: got err=%b req=%b adv=%0d want 1 0 1", fetch_err, imem_req, adv_cnt); end
    do_reset();
    tests_run++; if (fetch_err !== 1'b0) begin tests_failed++; $display("FAIL tmo_clear: got %b want 0", fetch_err); end
  endtask

  task automatic test_misaligned_wrap();
    do_reset();
    pc_in = 32'h102; pc_follow = 0;
    cycle(1'b0, 1'b1);
    tests_run++; if (adv_cnt !== 0 || fetch_err !== 1'b1 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL mis_err: got adv=%0d err=%b req=%b want 0 1 0", adv_cnt, fetch_err, imem_req); end
    pc_in = 32'h104;
    repeat (4) cycle(1'b0, 1'b1);
    tests_run++; if (adv_cnt !== 0 || imem_req !== 1'b0 || fetch_err !== 1'b1) begin tests_failed++; $display("FAIL mis_sticky: got adv=%0d req=%b err=%b want 0 0 1", adv_cnt, imem_req, fetch_err); end
    do_reset();
    pc_in = 32'hFFFFFFFC;
    for (int i = 0; i < 20 && got_pc.size() < 2; i++) cycle(1'b0, 1'b1);
    tests_run++; if (got_pc[0] !== 32'hFFFFFFFC || got_pc4[0] !== 32'h0 || got_ins[0] !== (32'hFFFFFFFC ^ KEY)) begin tests_failed++; $display("FAIL wrap_top: got pc=%h pc4=%h ins=%h want fffffffc 0 %h", got_pc[0], got_pc4[0], got_ins[0], 32'hFFFFFFFC ^ KEY); end
    tests_run++; if (got_pc[1] !== 32'h0 || got_pc4[1] !== 32'h4) begin tests_failed++; $display("FAIL wrap_next: got pc=%h pc4=%h want 0 4", got_pc[1], got_pc4[1]); end
  endtask

  initial begin
    reset = 1'b1; pc_in = 32'h0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    mem_lat = 0; mem_never = 0; bad_data = 0; pc_follow = 1; saw_bad = 0;
    req_cycles = 0; adv_cnt = 0; req_seen = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_busy();
    test_flush_ack();
    test_timeout();
    test_misaligned_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
